// File: rtl/cc_muxnto1_scan.sv
// cc_muxnto1_scan: N-channel, W-bit registered multiplexer with a direct
// (load-strobed) mode and an automatic masked scan mode.
module cc_muxnto1_scan #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SEL_WIDTH   = 2,
  parameter int unsigned DWELL       = 1000,
  parameter int unsigned DWELL_WIDTH = 16
) (
  input  logic                         CC_MUXNTO1_CLOCK_50,
  input  logic                         CC_MUXNTO1_RESET_InHigh,
  input  logic                         CC_MUXNTO1_mode_In,
  input  logic                         CC_MUXNTO1_load_In,
  input  logic [SEL_WIDTH-1:0]         CC_MUXNTO1_select_In,
  input  logic [NUM_CH-1:0]            CC_MUXNTO1_chmask_In,
  input  logic [NUM_CH*DATA_WIDTH-1:0] CC_MUXNTO1_data_In,
  output logic [DATA_WIDTH-1:0]        CC_MUXNTO1_data_Out,
  output logic [SEL_WIDTH-1:0]         CC_MUXNTO1_channel_Out,
  output logic                         CC_MUXNTO1_strobe_Out
);

  // One extra bit so current+offset can exceed NUM_CH-1 before folding.
  localparam int unsigned XW = SEL_WIDTH + 1;
  localparam logic [XW-1:0] NUM_CH_X = XW'(NUM_CH);
  localparam logic [DWELL_WIDTH-1:0] DWELL_LAST = DWELL_WIDTH'(DWELL - 1);

  typedef enum logic {
    ST_DIRECT = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [SEL_WIDTH-1:0]   ch_q, ch_d;
  logic [SEL_WIDTH-1:0]   adv_ch;
  logic                   adv_found;
  logic [XW-1:0]          cand;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  data_q, sel_data;
  logic                   strobe_q;

  // Next enabled channel after the current one, ascending, modulo NUM_CH.
  always_comb begin
    adv_ch    = ch_q;
    adv_found = 1'b0;
    cand      = '0;
    for (int unsigned i = 1; i < NUM_CH; i++) begin
      cand = {1'b0, ch_q} + XW'(i);
      if (cand >= NUM_CH_X) begin
        cand = cand - NUM_CH_X;
      end
      if (!adv_found && CC_MUXNTO1_chmask_In[cand[SEL_WIDTH-1:0]]) begin
        adv_found = 1'b1;
        adv_ch    = cand[SEL_WIDTH-1:0];
      end
    end
  end

  // Data slice of the currently registered channel (only in-range indices exist).
  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (ch_q == SEL_WIDTH'(k)) begin
        sel_data = CC_MUXNTO1_data_In[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state, channel and dwell-counter logic.
  always_comb begin
    state_d = CC_MUXNTO1_mode_In ? ST_SCAN : ST_DIRECT;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    if (state_q == ST_SCAN) begin
      if (cnt_q == DWELL_LAST) begin
        cnt_d = '0;
        ch_d  = adv_ch;
      end else begin
        cnt_d = cnt_q + DWELL_WIDTH'(1);
      end
    end else begin
      // Counter parked at zero so a switch into scan starts a fresh dwell.
      cnt_d = '0;
      if (CC_MUXNTO1_load_In && (32'(CC_MUXNTO1_select_In) < NUM_CH)) begin
        ch_d = CC_MUXNTO1_select_In;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CC_MUXNTO1_CLOCK_50) begin
    if (CC_MUXNTO1_RESET_InHigh) begin
      state_q  <= ST_DIRECT;
      ch_q     <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      data_q   <= sel_data;
      strobe_q <= (ch_d != ch_q);
    end
  end

  assign CC_MUXNTO1_data_Out    = data_q;
  assign CC_MUXNTO1_channel_Out = ch_q;
  assign CC_MUXNTO1_strobe_Out  = strobe_q;

endmodule

// File: tb/tb_cc_muxnto1_scan.sv
// Directed self-checking bench for cc_muxnto1_scan (three parameterisations).
module tb_cc_muxnto1_scan;

  logic clk;

  // Instance A: NUM_CH=4, DWELL=4
  logic        rst, mode, load;
  logic [1:0]  sel;
  logic [3:0]  mask;
  logic [31:0] data4;
  logic [7:0]  dout4;
  logic [1:0]  ch4;
  logic        stb4;

  // Instance B: NUM_CH=3, DWELL=4
  logic        rst3, mode3, load3;
  logic [1:0]  sel3;
  logic [2:0]  mask3;
  logic [23:0] data3;
  logic [7:0]  dout3;
  logic [1:0]  ch3;
  logic        stb3;

  // Instance C: NUM_CH=4, DWELL=1
  logic        rst1, mode1, load1;
  logic [1:0]  sel1;
  logic [3:0]  mask1;
  logic [7:0]  dout1;
  logic [1:0]  ch1;
  logic        stb1;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic [7:0] dat [4];
  int seq_full [4];
  int seq_mask [4];
  int prev;

  cc_muxnto1_scan #(.DATA_WIDTH(8), .NUM_CH(4), .SEL_WIDTH(2), .DWELL(4), .DWELL_WIDTH(16)) u_a (
    .CC_MUXNTO1_CLOCK_50(clk), .CC_MUXNTO1_RESET_InHigh(rst), .CC_MUXNTO1_mode_In(mode),
    .CC_MUXNTO1_load_In(load), .CC_MUXNTO1_select_In(sel), .CC_MUXNTO1_chmask_In(mask),
    .CC_MUXNTO1_data_In(data4), .CC_MUXNTO1_data_Out(dout4), .CC_MUXNTO1_channel_Out(ch4),
    .CC_MUXNTO1_strobe_Out(stb4));

  cc_muxnto1_scan #(.DATA_WIDTH(8), .NUM_CH(3), .SEL_WIDTH(2), .DWELL(4), .DWELL_WIDTH(16)) u_b (
    .CC_MUXNTO1_CLOCK_50(clk), .CC_MUXNTO1_RESET_InHigh(rst3), .CC_MUXNTO1_mode_In(mode3),
    .CC_MUXNTO1_load_In(load3), .CC_MUXNTO1_select_In(sel3), .CC_MUXNTO1_chmask_In(mask3),
    .CC_MUXNTO1_data_In(data3), .CC_MUXNTO1_data_Out(dout3), .CC_MUXNTO1_channel_Out(ch3),
    .CC_MUXNTO1_strobe_Out(stb3));

  cc_muxnto1_scan #(.DATA_WIDTH(8), .NUM_CH(4), .SEL_WIDTH(2), .DWELL(1), .DWELL_WIDTH(4)) u_c (
    .CC_MUXNTO1_CLOCK_50(clk), .CC_MUXNTO1_RESET_InHigh(rst1), .CC_MUXNTO1_mode_In(mode1),
    .CC_MUXNTO1_load_In(load1), .CC_MUXNTO1_select_In(sel1), .CC_MUXNTO1_chmask_In(mask1),
    .CC_MUXNTO1_data_In(data4), .CC_MUXNTO1_data_Out(dout1), .CC_MUXNTO1_channel_Out(ch1),
    .CC_MUXNTO1_strobe_Out(stb1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    dat[0] = 8'hA1; dat[1] = 8'hB2; dat[2] = 8'hC3; dat[3] = 8'hD4;
    seq_full[0] = 1; seq_full[1] = 2; seq_full[2] = 3; seq_full[3] = 0;
    seq_mask[0] = 1; seq_mask[1] = 3; seq_mask[2] = 1; seq_mask[3] = 3;

    rst = 1'b1; mode = 1'b0; load = 1'b0; sel = 2'd0; mask = 4'b1111;
    data4 = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    rst3 = 1'b1; mode3 = 1'b0; load3 = 1'b0; sel3 = 2'd0; mask3 = 3'b111;
    data3 = {8'hC3, 8'hB2, 8'hA1};
    rst1 = 1'b1; mode1 = 1'b0; load1 = 1'b0; sel1 = 2'd0; mask1 = 4'b0000;

    // Reset state
    step();
    check("rst_ch", 32'(ch4), 32'd0);
    check("rst_data", 32'(dout4), 32'h00);
    check("rst_strobe", 32'(stb4), 32'd0);

    // Idle direct mode: channel 0 data appears on the 2nd edge
    rst = 1'b0;
    step();
    check("idle_data", 32'(dout4), 32'hA1);
    check("idle_ch", 32'(ch4), 32'd0);
    check("idle_strobe", 32'(stb4), 32'd0);

    // Direct load of channel 2
    load = 1'b1; sel = 2'd2;
    step();
    check("load2_ch", 32'(ch4), 32'd2);
    check("load2_strobe", 32'(stb4), 32'd1);
    check("load2_data_trail", 32'(dout4), 32'hA1);
    load = 1'b0;
    step();
    check("load2_strobe_end", 32'(stb4), 32'd0);
    check("load2_data", 32'(dout4), 32'hC3);

    // Reloading the same index gives no strobe
    load = 1'b1; sel = 2'd2;
    step();
    check("reload_ch", 32'(ch4), 32'd2);
    check("reload_strobe", 32'(stb4), 32'd0);

    // Back to channel 0, then enter scan with all channels enabled
    sel = 2'd0;
    step();
    check("load0_ch", 32'(ch4), 32'd0);
    check("load0_strobe", 32'(stb4), 32'd1);
    load = 1'b0; mode = 1'b1;
    step();
    check("scan_enter_ch", 32'(ch4), 32'd0);
    check("scan_enter_strobe", 32'(stb4), 32'd0);
    check("scan_enter_data", 32'(dout4), 32'hA1);

    prev = 0;
    for (int s = 0; s < 4; s++) begin
      for (int h = 0; h < 3; h++) begin
        step();
        check("full_hold_ch", 32'(ch4), 32'(prev));
        check("full_hold_strobe", 32'(stb4), 32'd0);
        check("full_hold_data", 32'(dout4), 32'(dat[prev]));
      end
      step();
      check("full_adv_ch", 32'(ch4), 32'(seq_full[s]));
      check("full_adv_strobe", 32'(stb4), 32'd1);
      check("full_adv_data", 32'(dout4), 32'(dat[prev]));
      prev = seq_full[s];
    end

    // Sparse mask 1010 from channel 0
    mask = 4'b1010;
    for (int s = 0; s < 4; s++) begin
      for (int h = 0; h < 3; h++) begin
        step();
        check("mask_hold_ch", 32'(ch4), 32'(prev));
        check("mask_hold_strobe", 32'(stb4), 32'd0);
      end
      step();
      check("mask_adv_ch", 32'(ch4), 32'(seq_mask[s]));
      check("mask_adv_strobe", 32'(stb4), 32'd1);
      prev = seq_mask[s];
    end

    // All masked: hold on channel 3; load is ignored while scanning
    mask = 4'b0000; load = 1'b1; sel = 2'd1;
    for (int h = 0; h < 20; h++) begin
      step();
      check("allmask_ch", 32'(ch4), 32'd3);
      check("allmask_strobe", 32'(stb4), 32'd0);
    end
    check("allmask_data", 32'(dout4), 32'hD4);

    // Reset mid-scan
    load = 1'b0; rst = 1'b1;
    step();
    check("midrst_ch", 32'(ch4), 32'd0);
    check("midrst_data", 32'(dout4), 32'h00);
    check("midrst_strobe", 32'(stb4), 32'd0);

    // FSM is back in DIRECT: a load is honoured on the first edge
    rst = 1'b0; mode = 1'b0; load = 1'b1; sel = 2'd1;
    step();
    check("postrst_load_ch", 32'(ch4), 32'd1);
    check("postrst_load_strobe", 32'(stb4), 32'd1);

    // Mode toggle mid-dwell restarts the dwell counter
    load = 1'b0; mask = 4'b1111; mode = 1'b1;
    step();
    check("toggle_a_strobe", 32'(stb4), 32'd0);
    step();
    step();
    check("toggle_c_ch", 32'(ch4), 32'd1);
    mode = 1'b0;
    step();
    check("toggle_d_ch", 32'(ch4), 32'd1);
    mode = 1'b1;
    step();
    check("toggle_e_ch", 32'(ch4), 32'd1);
    for (int h = 0; h < 3; h++) begin
      step();
      check("toggle_hold_ch", 32'(ch4), 32'd1);
      check("toggle_hold_strobe", 32'(stb4), 32'd0);
    end
    step();
    check("toggle_adv_ch", 32'(ch4), 32'd2);
    check("toggle_adv_strobe", 32'(stb4), 32'd1);

    // NUM_CH=3: out-of-range select ignored, scan wraps 2 -> 0
    rst3 = 1'b0; load3 = 1'b1; sel3 = 2'd1;
    step();
    check("n3_load1_ch", 32'(ch3), 32'd1);
    check("n3_load1_strobe", 32'(stb3), 32'd1);
    sel3 = 2'd3;
    step();
    check("n3_oor_ch", 32'(ch3), 32'd1);
    check("n3_oor_strobe", 32'(stb3), 32'd0);
    load3 = 1'b0;
    step();
    check("n3_data", 32'(dout3), 32'hB2);
    load3 = 1'b1; sel3 = 2'd2;
    step();
    check("n3_load2_ch", 32'(ch3), 32'd2);
    load3 = 1'b0; mode3 = 1'b1;
    step();
    for (int h = 0; h < 3; h++) begin
      step();
      check("n3_hold_ch", 32'(ch3), 32'd2);
    end
    step();
    check("n3_wrap_ch", 32'(ch3), 32'd0);
    check("n3_wrap_strobe", 32'(stb3), 32'd1);
    check("n3_wrap_data_trail", 32'(dout3), 32'hC3);
    step();
    check("n3_wrap_data", 32'(dout3), 32'hA1);

    // DWELL=1 with only channel 2 enabled
    rst1 = 1'b0; mode1 = 1'b1; mask1 = 4'b0100;
    step();
    check("d1_enter_ch", 32'(ch1), 32'd0);
    check("d1_enter_strobe", 32'(stb1), 32'd0);
    step();
    check("d1_jump_ch", 32'(ch1), 32'd2);
    check("d1_jump_strobe", 32'(stb1), 32'd1);
    check("d1_jump_data", 32'(dout1), 32'hA1);
    step();
    check("d1_data", 32'(dout1), 32'hC3);
    for (int h = 0; h < 5; h++) begin
      check("d1_hold_ch", 32'(ch1), 32'd2);
      check("d1_hold_strobe", 32'(stb1), 32'd0);
      step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
